apb_shared_master_arb: RTL and testbench
========================================

# apb_shared_master_arb

Round-robin arbiter that shares one APB master port between `NUM_REQ` APB requesters, typically several AXI-to-APB bridges feeding a single 12-bit-address peripheral segment. Each requester presents a standard APB master interface. The arbiter grants one requester at a time, registers its address, direction and write data, and replays the transfer on the shared bus with its own SETUP/ACCESS sequencing. An optional watchdog terminates transfers that stall on `PREADY`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `APB_ADDR_WIDTH`, 12: PADDR width.
- `APB_DATA_WIDTH`, 32: PWDATA/PRDATA width.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before forced error (watchdog builds only), ≥1.

Ports. Clock and reset come first. Requester signals are flattened vectors, with requester k at slice k.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_psel_i` in NUM_REQ: per-requester PSEL.
- `req_penable_i` in NUM_REQ: per-requester PENABLE.
- `req_pwrite_i` in NUM_REQ: per-requester PWRITE.
- `req_paddr_i` in NUM_REQ*APB_ADDR_WIDTH: per-requester PADDR.
- `req_pwdata_i` in NUM_REQ*APB_DATA_WIDTH: per-requester PWDATA.
- `req_prdata_o` out APB_DATA_WIDTH: shared PRDATA; valid only with the granted requester's PREADY.
- `req_pready_o` out NUM_REQ: per-requester PREADY, one-hot or zero.
- `req_pslverr_o` out NUM_REQ: per-requester PSLVERR; meaningful only with its PREADY.
- `grant_o` out NUM_REQ: one-hot current owner; zero in IDLE.
- `mst_psel_o` out 1: shared-bus PSEL.
- `mst_penable_o` out 1: shared-bus PENABLE.
- `mst_pwrite_o` out 1: shared-bus PWRITE.
- `mst_paddr_o` out APB_ADDR_WIDTH: shared-bus PADDR.
- `mst_pwdata_o` out APB_DATA_WIDTH: shared-bus PWDATA.
- `mst_prdata_i` in APB_DATA_WIDTH: shared-bus PRDATA.
- `mst_pready_i` in 1: shared-bus PREADY.
- `mst_pslverr_i` in 1: shared-bus PSLVERR.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any `req_psel_i` bit is high, select a winner by round-robin.
  - Search starts at `last+1` mod NUM_REQ and picks the first requester with PSEL high.
  - Register the winner's index into `grant_o`, and its paddr/pwrite/pwdata into the `mst_*` holding registers.
  - Update `last`. Go to SETUP.
- **SETUP:** `mst_psel_o`=1, `mst_penable_o`=0, for exactly one cycle. Then go to ACCESS.
- **ACCESS:**
  - `mst_psel_o`=1 and `mst_penable_o`=1.
  - Hold until `mst_pready_i`=1.
  - In that cycle, drive combinationally: `req_pready_o[g]`=1, `req_pslverr_o[g]`=`mst_pslverr_i`, `req_prdata_o`=`mst_prdata_i`.
  - Next state IDLE; clear `grant_o` and the `mst_psel`/`mst_penable` outputs.
- `req_prdata_o` is 0 whenever no PREADY is returned.
- Non-granted requesters see PREADY=0 and are simply stalled; a requester must hold its PSEL and payload until it receives PREADY.
- Arbitration samples only PSEL. Requester PENABLE is not used for arbitration; it may be checked for protocol assertions only.
- `mst_paddr_o`/`mst_pwrite_o`/`mst_pwdata_o` hold their last value between transfers, and reset to 0.
- Reset values:
  - `last` = NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0; FSM is IDLE.

## Timing
- Arbitration request at cycle 0 (IDLE, PSEL high) gives `mst_psel_o` at cycle 1 and `mst_penable_o` at cycle 2.
- With zero-wait-state PREADY, requester PREADY occurs at cycle 2. Minimum transfer is 3 cycles including arbitration.
- Back-to-back: IDLE is re-entered for one cycle between transfers, so the next grant's SETUP starts 2 cycles after the previous PREADY.
- Simultaneous requests: exactly one is granted per arbitration. Each pending requester is served within NUM_REQ transfers.
- A requester dropping PSEL while not granted is legal and is ignored.
- `rst_i` asserted mid-transfer:
  - All outputs go to 0 immediately (asynchronous).
  - The in-flight transfer is aborted with no PREADY returned; `last` is reset.

## Configuration
- `APB_ARB_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` is cleared on SETUP and increments each ACCESS cycle without PREADY.
  - When the counter equals TIMEOUT_CYCLES and `mst_pready_i`=0, the arbiter:
    - forces `req_pready_o[g]`=1, `req_pslverr_o[g]`=1 and `req_prdata_o`=0;
    - deasserts `mst_psel_o`/`mst_penable_o` next cycle;
    - returns to IDLE.
  - A real PREADY in the same cycle takes precedence; no error is forced.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is ignored.

## Test plan
- **Single write:** req0 write addr 0x010, data 0xDEADBEEF, PREADY tied 1 → `mst_paddr_o`=0x010 and `mst_pwdata_o`=0xDEADBEEF at cycles 1-2; `req_pready_o`=4'b0001 at cycle 2, PSLVERR 0.
- **Round-robin:** all 4 requesters hold PSEL → grant order 0,1,2,3,0. Then requester 2 only → the next grant is 2.
- **Wait states and error:** req3 read 0x0FC; slave holds PREADY low 5 cycles, then returns PREADY=1, PRDATA=0x12345678, PSLVERR=1 → req3 sees those exact values in one cycle; other PREADYs stay 0.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** PREADY never asserted → requester gets PREADY=1, PSLVERR=1, PRDATA=0 after 8 ACCESS cycles; `mst_psel_o` is 0 on the following cycle.
- **Reset mid-ACCESS:** `rst_i` pulsed during ACCESS of req1 → all outputs 0 without waiting for a clock edge. Once `rst_i` deasserts, simultaneous req0/req1 requests are granted to req0 first.

Source files
------------

// File: rtl/apb_shared_master_arb.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ APB requesters.
// Optional PREADY watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_shared_master_arb #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_psel_i,
    input  logic [NUM_REQ-1:0]                 req_penable_i,
    input  logic [NUM_REQ-1:0]                 req_pwrite_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_paddr_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]          req_prdata_o,
    output logic [NUM_REQ-1:0]                 req_pready_o,
    output logic [NUM_REQ-1:0]                 req_pslverr_o,
    output logic [NUM_REQ-1:0]                 grant_o,
    output logic                               mst_psel_o,
    output logic                               mst_penable_o,
    output logic                               mst_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          mst_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          mst_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]          mst_prdata_i,
    input  logic                               mst_pready_i,
    input  logic                               mst_pslverr_i
);

    localparam int unsigned IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                    state;
    logic [IDXW-1:0]           last;
    logic [IDXW-1:0]           winner;
    logic [IDXW-1:0]           cand;
    logic                      found;
    logic                      tmo_hit;
    logic                      xfer_done;
    logic [APB_ADDR_WIDTH-1:0] paddr_arr [NUM_REQ];
    logic [APB_DATA_WIDTH-1:0] pwdata_arr [NUM_REQ];

    // Requester PENABLE carries no information the arbiter needs.
    logic penable_unused;
    assign penable_unused = ^req_penable_i;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign paddr_arr[g]  = req_paddr_i[g*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        assign pwdata_arr[g] = req_pwdata_i[g*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end

    // Search starts just after the previous owner, so the previous owner is checked last.
    always_comb begin
        found  = 1'b0;
        winner = last;
        cand   = last;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDXW'((32'(last) + i) % NUM_REQ);
            if (!found && req_psel_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (state == ACCESS) && !mst_pready_i && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS && !mst_pready_i && !tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;

    assign tmo_hit = 1'b0;
`endif

    assign xfer_done = (state == ACCESS) && (mst_pready_i || tmo_hit);

    // Response path is combinational so the requester completes in the slave's PREADY cycle.
    always_comb begin
        req_pready_o  = '0;
        req_pslverr_o = '0;
        req_prdata_o  = '0;
        if (xfer_done) begin
            req_pready_o  = grant_o;
            req_pslverr_o = grant_o & {NUM_REQ{mst_pready_i ? mst_pslverr_i : 1'b1}};
        end
        if (state == ACCESS && mst_pready_i) begin
            req_prdata_o = mst_prdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            last          <= IDXW'(NUM_REQ - 1);
            grant_o       <= '0;
            mst_psel_o    <= 1'b0;
            mst_penable_o <= 1'b0;
            mst_pwrite_o  <= 1'b0;
            mst_paddr_o   <= '0;
            mst_pwdata_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_o      <= NUM_REQ'(1) << winner;
                        last         <= winner;
                        mst_paddr_o  <= paddr_arr[winner];
                        mst_pwdata_o <= pwdata_arr[winner];
                        mst_pwrite_o <= req_pwrite_i[winner];
                        mst_psel_o   <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    mst_penable_o <= 1'b1;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_done) begin
                        grant_o       <= '0;
                        mst_psel_o    <= 1'b0;
                        mst_penable_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_shared_master_arb.sv
// Self-checking bench for apb_shared_master_arb: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_apb_shared_master_arb;

    localparam int N   = 4;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef APB_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  r_psel, r_pen, r_pwrite;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_data [N];
    logic [N*AW-1:0] req_paddr;
    logic [N*DW-1:0] req_pwdata;
    logic [DW-1:0] req_prdata;
    logic [N-1:0]  req_pready, req_pslverr, grant;
    logic          mst_psel, mst_penable, mst_pwrite;
    logic [AW-1:0] mst_paddr;
    logic [DW-1:0] mst_pwdata, mst_prdata;
    logic          mst_pready, mst_pslverr;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_paddr[g*AW +: AW]  = r_addr[g];
        assign req_pwdata[g*DW +: DW] = r_data[g];
    end

    always #5 clk = ~clk;

    apb_shared_master_arb #(
        .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_psel_i(r_psel), .req_penable_i(r_pen), .req_pwrite_i(r_pwrite),
        .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
        .req_prdata_o(req_prdata), .req_pready_o(req_pready), .req_pslverr_o(req_pslverr),
        .grant_o(grant),
        .mst_psel_o(mst_psel), .mst_penable_o(mst_penable), .mst_pwrite_o(mst_pwrite),
        .mst_paddr_o(mst_paddr), .mst_pwdata_o(mst_pwdata),
        .mst_prdata_i(mst_prdata), .mst_pready_i(mst_pready), .mst_pslverr_i(mst_pslverr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } job_t;

    job_t q [N][$];
    bit   active [N];
    bit   done_seen [N];

    // Requesters: hold PSEL and payload from job load until PREADY is seen.
    initial begin
        job_t j;
        bit   loaded;
        r_psel = '0; r_pen = '0; r_pwrite = '0;
        for (int k = 0; k < N; k++) begin
            r_addr[k] = '0; r_data[k] = '0; active[k] = 0; done_seen[k] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                loaded = 0;
                if (rst) begin
                    q[k].delete();
                    active[k] = 0;
                end else begin
                    if (done_seen[k]) active[k] = 0;
                    if (!active[k] && q[k].size() > 0) begin
                        j = q[k].pop_front();
                        r_pwrite[k] = j.wr; r_addr[k] = j.addr; r_data[k] = j.data;
                        active[k] = 1; loaded = 1;
                    end
                end
                done_seen[k] = 0;
                r_pen[k]  = active[k] && !loaded;
                r_psel[k] = active[k];
            end
        end
    end

    // Slave: PREADY after slv_wait ACCESS cycles; junk on PRDATA/PSLVERR otherwise.
    int            slv_wait  = 0;
    bit            slv_never = 0;
    bit            slv_err   = 0;
    logic [DW-1:0] slv_rdata = '0;

    initial begin
        int wcnt;
        wcnt = 0; mst_pready = 0; mst_prdata = '0; mst_pslverr = 0;
        forever begin
            @(posedge clk); #1;
            if (mst_psel && mst_penable) begin
                mst_pready = !slv_never && (wcnt >= slv_wait);
                wcnt++;
            end else begin
                wcnt = 0;
                mst_pready = 0;
            end
            mst_prdata  = mst_pready ? slv_rdata : (32'hBAD0_0000 | 32'(wcnt));
            mst_pslverr = mst_pready ? slv_err : 1'b1;
        end
    end

    // Transaction model: owner and age of the current transfer (age 0 = setup cycle).
    bit            m_busy;
    int            m_owner, m_last, m_age;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    int            glog [$];
    logic [N-1:0]  prev_grant, last_pready, last_err;
    logic [DW-1:0] last_rdata;
    int            stall, last_stall;
    bit            post;
    logic          psel_after;

    always @(negedge clk) begin
        logic [N-1:0]  e_grant, e_pready, e_err;
        logic [DW-1:0] e_rdata;
        bit            acc, tmo, done;
        int            k;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_age = 0;
            m_wr = 0; m_addr = '0; m_data = '0;
            prev_grant = '0; stall = 0; post = 0;
            chk("rst_grant", grant, 0);
            chk("rst_psel", mst_psel, 0);
            chk("rst_penable", mst_penable, 0);
            chk("rst_paddr", mst_paddr, 0);
            chk("rst_pwdata", mst_pwdata, 0);
            chk("rst_pready", req_pready, 0);
        end else begin
            e_grant = '0;
            if (m_busy) e_grant[m_owner] = 1'b1;
            acc  = m_busy && m_age > 0;
            tmo  = TMO_EN && acc && !mst_pready && (m_age - 1 == TMO);
            done = acc && (mst_pready || tmo);
            e_pready = done ? e_grant : '0;
            e_err    = (done && (mst_pready ? mst_pslverr : 1'b1)) ? e_grant : '0;
            e_rdata  = (acc && mst_pready) ? mst_prdata : '0;
            chk("m_grant", grant, e_grant);
            chk("m_psel", mst_psel, m_busy);
            chk("m_penable", mst_penable, acc);
            chk("m_pwrite", mst_pwrite, m_wr);
            chk("m_paddr", mst_paddr, m_addr);
            chk("m_pwdata", mst_pwdata, m_data);
            chk("m_pready", req_pready, e_pready);
            chk("m_pslverr", req_pslverr, e_err);
            chk("m_prdata", req_prdata, e_rdata);

            if (grant != 0 && prev_grant == 0)
                for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
            prev_grant = grant;
            if (post) begin
                psel_after = mst_psel;
                post = 0;
            end
            if (req_pready != 0) begin
                last_pready = req_pready; last_err = req_pslverr; last_rdata = req_prdata;
                last_stall = stall; stall = 0; post = 1;
                for (int i = 0; i < N; i++) if (req_pready[i]) done_seen[i] = 1;
            end else if (mst_penable) begin
                stall++;
            end

            if (!m_busy) begin
                for (int i = 1; i <= N; i++) begin
                    k = (m_last + i) % N;
                    if (!m_busy && r_psel[k]) begin
                        m_busy = 1; m_owner = k; m_last = k; m_age = 0;
                        m_wr = r_pwrite[k]; m_addr = r_addr[k]; m_data = r_data[k];
                    end
                end
            end else if (done) begin
                m_busy = 0;
            end else begin
                m_age++;
            end
        end
    end

    function automatic bit all_idle();
        bit r = (grant == 0) && (r_psel == 0);
        for (int k = 0; k < N; k++) if (q[k].size() != 0 || active[k]) r = 0;
        return r;
    endfunction

    task automatic wait_idle(input int maxc, input string nm);
        bit ok = 0;
        for (int n = 0; n < maxc && !ok; n++) begin
            @(negedge clk);
            ok = all_idle();
        end
        chk(nm, ok, 1);
        @(posedge clk); #2;
    endtask

    task automatic push(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        job_t j;
        j.wr = wr; j.addr = a; j.data = d;
        q[k].push_back(j);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2; rst = 1;
        @(posedge clk); #2;
        @(posedge clk); #2; rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  rr_exp [5] = '{0, 1, 2, 3, 0};
        bit  seen;
        rst = 1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("reset_grant", grant, 0);
        chk("reset_psel", mst_psel, 0);
        @(posedge clk); #2; rst = 0;

        // Single zero-wait write from requester 0.
        push(0, 1'b1, 12'h010, 32'hDEADBEEF);
        @(posedge clk); #2;
        @(negedge clk);
        chk("w_c0_psel", mst_psel, 0);
        @(negedge clk);
        chk("w_c1_psel", mst_psel, 1);
        chk("w_c1_penable", mst_penable, 0);
        chk("w_c1_paddr", mst_paddr, 12'h010);
        chk("w_c1_pwdata", mst_pwdata, 32'hDEADBEEF);
        chk("w_c1_grant", grant, 4'b0001);
        @(negedge clk);
        chk("w_c2_penable", mst_penable, 1);
        chk("w_c2_paddr", mst_paddr, 12'h010);
        chk("w_c2_pwdata", mst_pwdata, 32'hDEADBEEF);
        chk("w_c2_pready", req_pready, 4'b0001);
        chk("w_c2_pslverr", req_pslverr, 4'b0000);
        wait_idle(20, "w_drain");

        // Round-robin with all requesters pending from reset.
        pulse_reset();
        glog.delete();
        push(0, 1'b1, 12'h100, 32'h0000_0A00);
        push(0, 1'b0, 12'h104, 32'h0000_0A01);
        push(1, 1'b1, 12'h200, 32'h0000_0B00);
        push(2, 1'b0, 12'h300, 32'h0000_0C00);
        push(3, 1'b1, 12'h400, 32'h0000_0D00);
        wait_idle(100, "rr_drain");
        chk("rr_count", glog.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_order%0d", i), (i < glog.size()) ? glog[i] : 99, rr_exp[i]);
        glog.delete();
        push(2, 1'b1, 12'h0A5, 32'h5A5A_5A5A);
        wait_idle(30, "rr2_drain");
        chk("rr_only2", (glog.size() > 0) ? glog[0] : 99, 2);

        // Wait states with slave error on a read.
        slv_wait = 5; slv_rdata = 32'h12345678; slv_err = 1;
        push(3, 1'b0, 12'h0FC, 32'h0);
        wait_idle(40, "ws_drain");
        chk("ws_pready", last_pready, 4'b1000);
        chk("ws_prdata", last_rdata, 32'h12345678);
        chk("ws_pslverr", last_err, 4'b1000);
        chk("ws_stall", last_stall, 5);
        chk("ws_paddr_hold", mst_paddr, 12'h0FC);
        slv_wait = 0; slv_err = 0;

`ifdef APB_ARB_TIMEOUT_EN
        slv_never = 1;
        push(1, 1'b0, 12'h123, 32'h0);
        wait_idle(60, "to_drain");
        chk("to_pready", last_pready, 4'b0010);
        chk("to_pslverr", last_err, 4'b0010);
        chk("to_prdata", last_rdata, 0);
        chk("to_stall", last_stall, TMO);
        chk("to_psel_after", psel_after, 0);
        slv_never = 0;
`endif

        // Asynchronous reset in the middle of requester 1's ACCESS phase.
        slv_wait = 20;
        push(1, 1'b1, 12'h0AA, 32'h55AA55AA);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            seen = mst_penable;
        end
        chk("ar_reached_access", seen, 1);
        #2 rst = 1;
        #1;
        chk("ar_grant", grant, 0);
        chk("ar_psel", mst_psel, 0);
        chk("ar_penable", mst_penable, 0);
        chk("ar_pwrite", mst_pwrite, 0);
        chk("ar_paddr", mst_paddr, 0);
        chk("ar_pwdata", mst_pwdata, 0);
        chk("ar_pready", req_pready, 0);
        chk("ar_prdata", req_prdata, 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        slv_wait = 0; rst = 0;
        glog.delete();
        push(0, 1'b0, 12'h011, 32'h0);
        push(1, 1'b1, 12'h022, 32'hCAFE0001);
        wait_idle(40, "ar_drain");
        chk("ar_first", (glog.size() > 0) ? glog[0] : 99, 0);
        chk("ar_second", (glog.size() > 1) ? glog[1] : 99, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
